// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: widths, op and state
// encodings, EX/MEM and MEM/WB bus payloads, and op classification helpers.
package mem_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam int unsigned EX_TO_MEM_BUS_W = 4 * XLEN + OP_W + 1 + REG_AW;
  localparam int unsigned MEM_TO_WB_BUS_W = 3 * XLEN + 1 + REG_AW;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_LD_B  = 4'd1,
    OP_LD_H  = 4'd2,
    OP_LD_W  = 4'd3,
    OP_LD_BU = 4'd4,
    OP_LD_HU = 4'd5,
    OP_ST_B  = 4'd6,
    OP_ST_H  = 4'd7,
    OP_ST_W  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   result;
    logic [OP_W-1:0]   mem_op;
    logic [XLEN-1:0]   store_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
  } ex_to_mem_bus_t;

  // Per-instruction context kept while the stage owns the instruction.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   addr;
    logic [OP_W-1:0]   mem_op;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
  } mem_ctx_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
  } mem_to_wb_bus_t;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op >= OP_W'(OP_LD_B)) && (op <= OP_W'(OP_LD_HU));
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op >= OP_W'(OP_ST_B)) && (op <= OP_W'(OP_ST_W));
  endfunction

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed byte/halfword/word from a data-SRAM read word and
// sign- or zero-extends it according to the load op.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [OP_W-1:0] mem_op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned low address bits are simply ignored for halfword/word loads.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    load_data_c = rdata;
    case (mem_op)
      OP_LD_B:  load_data_c = {{24{byte_sel[7]}}, byte_sel};
      OP_LD_BU: load_data_c = {24'd0, byte_sel};
      OP_LD_H:  load_data_c = {{16{half_sel[15]}}, half_sel};
      OP_LD_HU: load_data_c = {16'd0, half_sel};
      default:  load_data_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: captures an EX instruction, runs at most one data-SRAM
// request/response handshake for it, and hands the result to WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              mem_allowin,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_inst,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [OP_W-1:0]   ex_mem_op,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic              ex_rf_we,
  input  logic [REG_AW-1:0] ex_rf_waddr,
  output logic              data_req,
  output logic              data_wr,
  output logic [STRB_W-1:0] data_wstrb,
  output logic [XLEN-1:0]   data_addr,
  output logic [XLEN-1:0]   data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [XLEN-1:0]   data_rdata,
  input  logic              wb_allowin,
  output logic              mem_to_wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [XLEN-1:0]   wb_inst,
  output logic              wb_rf_we,
  output logic [REG_AW-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]   wb_rf_wdata
);

  mem_state_e        state_q, state_d;
  mem_ctx_t          ctx_q, ctx_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   st_data_q, st_data_d;

  ex_to_mem_bus_t    ex_bus_c;
  mem_to_wb_bus_t    wb_bus_c;
  logic              allowin_c;
  logic              capture_c;
  logic [STRB_W-1:0] st_wstrb_c;
  logic [XLEN-1:0]   st_wdata_c;
  logic [XLEN-1:0]   load_data_c;

  assign ex_bus_c = ex_to_mem_bus_t'(EX_TO_MEM_BUS_W'({ex_pc, ex_inst, ex_result, ex_mem_op,
                                                      ex_store_data, ex_rf_we, ex_rf_waddr}));

  assign allowin_c = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_allowin);
  assign capture_c = ex_valid && allowin_c;

  // Store byte lanes and replicated write data, derived from the EX inputs.
  always_comb begin
    st_wstrb_c = '0;
    st_wdata_c = '0;
    case (ex_bus_c.mem_op)
      OP_ST_B: begin
        st_wstrb_c = STRB_W'(4'b0001 << ex_bus_c.result[1:0]);
        st_wdata_c = {4{ex_bus_c.store_data[7:0]}};
      end
      OP_ST_H: begin
        st_wstrb_c = ex_bus_c.result[1] ? 4'b1100 : 4'b0011;
        st_wdata_c = {2{ex_bus_c.store_data[15:0]}};
      end
      OP_ST_W: begin
        st_wstrb_c = 4'b1111;
        st_wdata_c = ex_bus_c.store_data;
      end
      default: begin
        st_wstrb_c = '0;
        st_wdata_c = '0;
      end
    endcase
  end

  mem_load_align u_load_align (
    .mem_op      (ctx_q.mem_op),
    .addr_lo     (ctx_q.addr[1:0]),
    .rdata       (data_rdata),
    .load_data_c (load_data_c)
  );

  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    st_data_d = st_data_q;

    case (state_q)
      S_REQ: begin
        if (data_addr_ok) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          state_d = S_DONE;
          if (is_load(ctx_q.mem_op)) begin
            wdata_d = load_data_c;
          end
        end
      end
      S_DONE: begin
        if (wb_allowin && !ex_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase

    // Capture overrides the IDLE/DONE transitions above.
    if (capture_c) begin
      ctx_d.pc       = ex_bus_c.pc;
      ctx_d.inst     = ex_bus_c.inst;
      ctx_d.addr     = ex_bus_c.result;
      ctx_d.mem_op   = ex_bus_c.mem_op;
      ctx_d.rf_we    = ex_bus_c.rf_we && !is_store(ex_bus_c.mem_op);
      ctx_d.rf_waddr = ex_bus_c.rf_waddr;
      wdata_d        = ex_bus_c.result;
      wstrb_d        = st_wstrb_c;
      st_data_d      = st_wdata_c;
      state_d        = is_mem(ex_bus_c.mem_op) ? S_REQ : S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      st_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      st_data_q <= st_data_d;
    end
  end

  // Held low while in reset so every output reads 0 during reset.
  assign mem_allowin = rst_n && allowin_c;

  assign data_req   = (state_q == S_REQ);
  assign data_wr    = is_store(ctx_q.mem_op);
  assign data_wstrb = wstrb_q;
  assign data_addr  = {ctx_q.addr[XLEN-1:2], 2'b00};
  assign data_wdata = st_data_q;

  assign mem_to_wb_valid = (state_q == S_DONE);

  always_comb begin
    wb_bus_c          = '0;
    wb_bus_c.pc       = ctx_q.pc;
    wb_bus_c.inst     = ctx_q.inst;
    wb_bus_c.rf_we    = ctx_q.rf_we;
    wb_bus_c.rf_waddr = ctx_q.rf_waddr;
    wb_bus_c.rf_wdata = wdata_q;
  end

  assign {wb_pc, wb_inst, wb_rf_we, wb_rf_waddr, wb_rf_wdata} = MEM_TO_WB_BUS_W'(wb_bus_c);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected WB results are queued at issue time
// and popped when the stage presents a valid result.
module tb_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_allowin;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] ex_result;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_store_data;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  wb_exp_t sb[$];
  int n_checks = 0;
  int n_fails  = 0;

  mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid        (ex_valid),
    .mem_allowin     (mem_allowin),
    .ex_pc           (ex_pc),
    .ex_inst         (ex_inst),
    .ex_result       (ex_result),
    .ex_mem_op       (ex_mem_op),
    .ex_store_data   (ex_store_data),
    .ex_rf_we        (ex_rf_we),
    .ex_rf_waddr     (ex_rf_waddr),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_wstrb      (data_wstrb),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .wb_pc           (wb_pc),
    .wb_inst         (wb_inst),
    .wb_rf_we        (wb_rf_we),
    .wb_rf_waddr     (wb_rf_waddr),
    .wb_rf_wdata     (wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wb_exp_t obs_wb();
    return {wb_pc, wb_inst, wb_rf_we, wb_rf_waddr, wb_rf_wdata};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic we, input logic [4:0] wa, input logic [31:0] pc,
                       input logic [31:0] inst);
    ex_mem_op     = op;
    ex_result     = res;
    ex_store_data = sd;
    ex_rf_we      = we;
    ex_rf_waddr   = wa;
    ex_pc         = pc;
    ex_inst       = inst;
    ex_valid      = 1'b1;
    check("issue allowin", 128'(mem_allowin), 128'(1'b1));
    step();
    ex_valid = 1'b0;
  endtask

  // Waits up to budget cycles for a valid result, then checks it against the queue head.
  task automatic expect_wb(input string tag, input int budget);
    wb_exp_t e;
    int waited = 0;
    while (mem_to_wb_valid !== 1'b1 && waited < budget) begin
      step();
      waited++;
    end
    check({tag, " valid"}, 128'(mem_to_wb_valid), 128'(1'b1));
    if (mem_to_wb_valid === 1'b1) begin
      check({tag, " pending"}, 128'(sb.size() != 0), 128'(1'b1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, " wb"}, 128'(obs_wb()), 128'(e));
      end
    end
  endtask

  // Responds to the request presented right after capture; a stray data_ok is
  // injected while the address is still pending when addr_wait > 1.
  task automatic mem_xact(input string tag, input int addr_wait, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic e_wr, input logic [3:0] e_wstrb,
                          input logic [31:0] e_wdata);
    for (int i = 0; i <= addr_wait; i++) begin
      check({tag, " req"}, 128'({data_req, data_wr, data_wstrb, data_addr}),
            128'({1'b1, e_wr, e_wstrb, e_addr}));
      if (e_wr) check({tag, " wdata"}, 128'(data_wdata), 128'(e_wdata));
      if (i == addr_wait) data_addr_ok = 1'b1;
      else data_data_ok = (i == 1);
      step();
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
    end
    check({tag, " req dropped"}, 128'(data_req), 128'(1'b0));
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    step();
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0;
    ex_pc = '0; ex_inst = '0; ex_result = '0; ex_mem_op = '0;
    ex_store_data = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    wb_allowin = 1'b1;

    #7;
    check("rst allowin", 128'(mem_allowin), 128'(1'b0));
    check("rst req", 128'({data_req, data_wr, data_wstrb, data_addr, data_wdata}), 128'(0));
    check("rst valid", 128'(mem_to_wb_valid), 128'(1'b0));
    check("rst wb", 128'(obs_wb()), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle allowin", 128'(mem_allowin), 128'(1'b1));

    // ALU op passes straight through.
    sb.push_back('{pc: 32'h1c00_0000, inst: 32'h0010_0001, rf_we: 1'b1, waddr: 5'd5, wdata: 32'h0000_1234});
    issue(4'd0, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 32'h1c00_0000, 32'h0010_0001);
    check("alu no req", 128'(data_req), 128'(1'b0));
    expect_wb("alu", 0);
    step();

    sb.push_back('{pc: 32'h1c00_0004, inst: 32'h2800_0001, rf_we: 1'b1, waddr: 5'd6, wdata: 32'hFFFF_FF80});
    issue(4'd1, 32'h0000_1003, 32'h0, 1'b1, 5'd6, 32'h1c00_0004, 32'h2800_0001);
    mem_xact("ld.b", 0, 32'h80FF_FF7F, 32'h0000_1000, 1'b0, 4'b0000, 32'h0);
    expect_wb("ld.b", 0);
    step();

    sb.push_back('{pc: 32'h1c00_0008, inst: 32'h2a40_0002, rf_we: 1'b1, waddr: 5'd7, wdata: 32'h0000_BEEF});
    issue(4'd5, 32'h0000_2002, 32'h0, 1'b1, 5'd7, 32'h1c00_0008, 32'h2a40_0002);
    mem_xact("ld.hu", 1, 32'hBEEF_0000, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    expect_wb("ld.hu", 0);
    step();

    sb.push_back('{pc: 32'h1c00_000c, inst: 32'h2840_0003, rf_we: 1'b1, waddr: 5'd8, wdata: 32'hFFFF_BEEF});
    issue(4'd2, 32'h0000_2002, 32'h0, 1'b1, 5'd8, 32'h1c00_000c, 32'h2840_0003);
    mem_xact("ld.h", 1, 32'hBEEF_0000, 32'h0000_2000, 1'b0, 4'b0000, 32'h0);
    expect_wb("ld.h", 0);
    step();

    // Store: no write-back even though EX asserted rf_we; address held for 3 cycles.
    sb.push_back('{pc: 32'h1c00_0010, inst: 32'h2940_0004, rf_we: 1'b0, waddr: 5'd9, wdata: 32'h0000_3002});
    issue(4'd7, 32'h0000_3002, 32'h0000_ABCD, 1'b1, 5'd9, 32'h1c00_0010, 32'h2940_0004);
    mem_xact("st.h", 3, 32'h1357_9BDF, 32'h0000_3000, 1'b1, 4'b1100, 32'hABCD_ABCD);
    expect_wb("st.h", 0);
    step();

    sb.push_back('{pc: 32'h1c00_0014, inst: 32'h2900_0005, rf_we: 1'b0, waddr: 5'd10, wdata: 32'h0000_4001});
    issue(4'd6, 32'h0000_4001, 32'h1122_3344, 1'b0, 5'd10, 32'h1c00_0014, 32'h2900_0005);
    mem_xact("st.b", 0, 32'h0, 32'h0000_4000, 1'b1, 4'b0010, 32'h4444_4444);
    expect_wb("st.b", 0);
    step();

    sb.push_back('{pc: 32'h1c00_0018, inst: 32'h2980_0006, rf_we: 1'b0, waddr: 5'd11, wdata: 32'h0000_500C});
    issue(4'd8, 32'h0000_500C, 32'hDEAD_BEEF, 1'b1, 5'd11, 32'h1c00_0018, 32'h2980_0006);
    mem_xact("st.w", 2, 32'h0, 32'h0000_500C, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    expect_wb("st.w", 0);
    step();

    sb.push_back('{pc: 32'h1c00_001c, inst: 32'h2880_0007, rf_we: 1'b1, waddr: 5'd12, wdata: 32'hCAFE_F00D});
    issue(4'd3, 32'h0000_6003, 32'h0, 1'b1, 5'd12, 32'h1c00_001c, 32'h2880_0007);
    mem_xact("ld.w", 0, 32'hCAFE_F00D, 32'h0000_6000, 1'b0, 4'b0000, 32'h0);
    expect_wb("ld.w", 0);
    step();

    sb.push_back('{pc: 32'h1c00_0020, inst: 32'h2a00_0008, rf_we: 1'b1, waddr: 5'd13, wdata: 32'h0000_0080});
    issue(4'd4, 32'h0000_7001, 32'h0, 1'b1, 5'd13, 32'h1c00_0020, 32'h2a00_0008);
    mem_xact("ld.bu", 1, 32'h0000_8000, 32'h0000_7000, 1'b0, 4'b0000, 32'h0);
    expect_wb("ld.bu", 0);
    step();

    // Reserved op code behaves as a non-memory op.
    sb.push_back('{pc: 32'h1c00_0024, inst: 32'h0000_0009, rf_we: 1'b1, waddr: 5'd14, wdata: 32'hA5A5_0003});
    issue(4'd12, 32'hA5A5_0003, 32'h0, 1'b1, 5'd14, 32'h1c00_0024, 32'h0000_0009);
    check("op12 no req", 128'(data_req), 128'(1'b0));
    expect_wb("op12", 0);
    step();

    // Back-pressure: result held while WB stalls, next EX instruction waits.
    wb_allowin = 1'b0;
    sb.push_back('{pc: 32'h1c00_0028, inst: 32'h0000_000A, rf_we: 1'b1, waddr: 5'd15, wdata: 32'h0000_00AA});
    issue(4'd0, 32'h0000_00AA, 32'h0, 1'b1, 5'd15, 32'h1c00_0028, 32'h0000_000A);
    ex_mem_op = 4'd0; ex_result = 32'h0000_00BB; ex_rf_we = 1'b1; ex_rf_waddr = 5'd16;
    ex_pc = 32'h1c00_002c; ex_inst = 32'h0000_000B; ex_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp allowin", 128'(mem_allowin), 128'(1'b0));
      check("bp valid", 128'(mem_to_wb_valid), 128'(1'b1));
      check("bp hold", 128'(obs_wb()), 128'(sb[0]));
      step();
    end
    wb_allowin = 1'b1;
    #1;
    check("bp release allowin", 128'(mem_allowin), 128'(1'b1));
    sb.push_back('{pc: 32'h1c00_002c, inst: 32'h0000_000B, rf_we: 1'b1, waddr: 5'd16, wdata: 32'h0000_00BB});
    expect_wb("bp first", 0);
    step();
    ex_valid = 1'b0;
    expect_wb("bp second", 0);
    step();

    // Reset while waiting for data abandons the load; a late data_ok is ignored.
    issue(4'd3, 32'h0000_8000, 32'h0, 1'b1, 5'd17, 32'h1c00_0030, 32'h0000_000C);
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    check("wait allowin", 128'(mem_allowin), 128'(1'b0));
    rst_n = 1'b0;
    #1;
    check("mid rst allowin", 128'(mem_allowin), 128'(1'b0));
    check("mid rst req", 128'({data_req, data_wr, data_wstrb, data_addr, data_wdata}), 128'(0));
    check("mid rst valid", 128'(mem_to_wb_valid), 128'(1'b0));
    check("mid rst wb", 128'(obs_wb()), 128'(0));
    #2;
    rst_n = 1'b1;
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'h7777_7777;
    step();
    data_data_ok = 1'b0;
    check("stray ok allowin", 128'(mem_allowin), 128'(1'b1));
    for (int i = 0; i < 3; i++) begin
      check("stray ok valid", 128'({mem_to_wb_valid, data_req}), 128'(0));
      step();
    end
    check("scoreboard drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
